// File: rtl/sweep_cmd_loader_pkg.sv
// Shared types and constants for the sweep-instruction loader.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sweep_pkg;

    localparam int       INSTR_W     = 80;
    localparam int       INSTR_BYTES = 10;
    localparam bit [7:0] SYNC_BYTE   = 8'hA5;

    // One sweep instruction as it sits in the FIFO, MSB first on the wire
    typedef struct packed {
        logic [31:0] init_freq;
        logic [15:0] cycles_per_step;
        logic [31:0] freq_step;
    } sweep_instr_t;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

endpackage

// File: rtl/sweep_cmd_loader_if.sv
// Host byte link plus sweeper-side FIFO read port of the loader.
// Latency: n/a (wiring only).
// Backpressure: rx_ready from loader; fifo_rd_en from sweeper.
interface sweep_cmd_loader_if;
    import sweep_pkg::*;

    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    sweep_instr_t fifo_data;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic         fifo_full;
    logic         frame_err;
    logic [15:0]  cmd_count;

    // Environment side: host byte source and sweeper reader
    modport master (
        output rx_data, rx_valid, fifo_rd_en,
        input  rx_ready, fifo_data, fifo_empty, fifo_full, frame_err, cmd_count
    );

    // Loader side
    modport slave (
        input  rx_data, rx_valid, fifo_rd_en,
        output rx_ready, fifo_data, fifo_empty, fifo_full, frame_err, cmd_count
    );

endinterface

// File: rtl/sweep_cmd_loader_fifo.sv
// First-word-fall-through FIFO holding verified sweep instructions.
// Latency: write visible at the head one cycle after the write edge; no bypass.
// Backpressure: writes ignored while full, pops ignored while empty.
module sweep_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 80
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_dat_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_dat_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         empty_q, full_q;
    logic         do_wr, do_rd;

    assign do_wr = wr_en_i && !full_q;
    assign do_rd = rd_en_i && !empty_q;

    // Next pointer values; the extra MSB distinguishes full from empty
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    end

    // Pointers and flags, flags decoded from next pointers so they are registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= (wr_ptr_d == rd_ptr_d);
            full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                        (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        end
    end

    // Storage array; contents are meaningless until written so no reset
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o  = empty_q;
    assign full_o   = full_q;

endmodule

// File: rtl/sweep_cmd_loader.sv
// Deframes A5-synced, XOR-checked 80-bit sweep instructions into a FWFT FIFO.
// Latency: good frame visible at FIFO head 1 cycle after its checksum byte is accepted.
// Backpressure: rx_ready drops only while the checksum byte waits on a full FIFO.
// Optional: define SWEEP_CMD_TIMEOUT_EN to abandon frames after TIMEOUT_CYCLES idle cycles.
module sweep_cmd_loader
    import sweep_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    sweep_cmd_loader_if.slave    bus
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("sweep_cmd_loader: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
    end

    localparam logic [3:0] LAST_IDX = 4'(INSTR_BYTES - 1);

    state_t               state_q;
    logic [3:0]           idx_q;
    logic [INSTR_W-1:0]   shreg_q;
    logic [7:0]           csum_q;
    logic                 frame_err_q;
    logic [15:0]          cmd_count_q;

    logic                 rx_ready;
    logic                 accept;
    logic                 csum_ok;
    logic                 wr_en;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [INSTR_W-1:0]   head;

`ifdef SWEEP_CMD_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMR_W-1:0]     timer_q;
`endif

    // Only the checksum byte can be refused: it is the one that needs a free slot
    assign rx_ready = !(state_q == CHECK && fifo_full);
    assign accept   = bus.rx_valid && rx_ready;
    assign csum_ok  = (bus.rx_data == csum_q);
    assign wr_en    = accept && (state_q == CHECK) && csum_ok;

    // Deframer FSM with registered error pulse, command counter and idle timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            idx_q       <= '0;
            shreg_q     <= '0;
            csum_q      <= '0;
            frame_err_q <= 1'b0;
            cmd_count_q <= '0;
`ifdef SWEEP_CMD_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            if (wr_en) begin
                cmd_count_q <= cmd_count_q + 16'd1;
            end
            case (state_q)
                HUNT: begin
                    // Non-sync bytes are consumed and dropped
                    if (accept && bus.rx_data == SYNC_BYTE) begin
                        state_q <= PAYLOAD;
                        idx_q   <= '0;
                        csum_q  <= '0;
                    end
                end
                PAYLOAD: begin
                    // A5 here is payload data, never a resync
                    if (accept) begin
                        shreg_q <= {shreg_q[INSTR_W-9:0], bus.rx_data};
                        csum_q  <= csum_q ^ bus.rx_data;
                        if (idx_q == LAST_IDX) begin
                            state_q <= CHECK;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (!csum_ok) begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= HUNT;
                    end
                end
                default: begin
                    state_q <= HUNT;
                end
            endcase
`ifdef SWEEP_CMD_TIMEOUT_EN
            // Stalled cycles count too, so a host that never frees space still times out
            if (state_q != HUNT && !accept) begin
                if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_q     <= HUNT;
                    frame_err_q <= 1'b1;
                    timer_q     <= '0;
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
            end else begin
                timer_q <= '0;
            end
`endif
        end
    end

    sweep_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en_i  (wr_en),
        .wr_dat_i (shreg_q),
        .rd_en_i  (bus.fifo_rd_en),
        .rd_dat_o (head),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full)
    );

    assign bus.rx_ready   = rx_ready;
    assign bus.fifo_data  = head;
    assign bus.fifo_empty = fifo_empty;
    assign bus.fifo_full  = fifo_full;
    assign bus.frame_err  = frame_err_q;
    assign bus.cmd_count  = cmd_count_q;

endmodule

// File: tb/tb_sweep_cmd_loader.sv
// Directed bench for sweep_cmd_loader with a queue-based reference model.
// Latency: model pushes on the checksum edge; outputs compared each falling edge.
// Backpressure: host waits on rx_ready; sweeper pops via fifo_rd_en pulses.
module tb_sweep_cmd_loader;

    localparam int DEPTH = 4;
`ifdef SWEEP_CMD_TIMEOUT_EN
    localparam int TMO = 100;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   err_seen = 0;

    sweep_cmd_loader_if bus ();

    sweep_cmd_loader #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: list of stored instructions plus the bytes of the frame in progress
    logic [79:0] m_q[$];
    logic [7:0]  m_frm[$];
    logic        m_in_frame = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    logic        m_err = 1'b0;
    int          m_tmo = 0;

    function automatic logic exp_rdy();
        return !(m_in_frame && m_frm.size() == 10 && m_q.size() == DEPTH);
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin : model
        logic        acc;
        logic [7:0]  b;
        logic [7:0]  x;
        logic [79:0] v;
        if (reset) begin
            m_q.delete();
            m_frm.delete();
            m_in_frame = 1'b0;
            m_cnt      = 16'd0;
            m_err      = 1'b0;
            m_tmo      = 0;
        end else begin
            acc   = bus.rx_valid && exp_rdy();
            b     = bus.rx_data;
            m_err = 1'b0;
            if (bus.fifo_rd_en && m_q.size() > 0) void'(m_q.pop_front());
            if (acc) begin
                if (!m_in_frame) begin
                    if (b == 8'hA5) begin
                        m_in_frame = 1'b1;
                        m_frm.delete();
                    end
                end else if (m_frm.size() < 10) begin
                    m_frm.push_back(b);
                end else begin
                    x = 8'h00;
                    v = '0;
                    for (int i = 0; i < 10; i++) begin
                        x = x ^ m_frm[i];
                        v[79-8*i -: 8] = m_frm[i];
                    end
                    if (x == b) begin
                        m_q.push_back(v);
                        m_cnt = m_cnt + 16'd1;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_in_frame = 1'b0;
                end
                m_tmo = 0;
            end
`ifdef SWEEP_CMD_TIMEOUT_EN
            else if (m_in_frame) begin
                m_tmo++;
                if (m_tmo == TMO) begin
                    m_in_frame = 1'b0;
                    m_err      = 1'b1;
                    m_tmo      = 0;
                end
            end
`endif
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_fifo_empty", bus.fifo_empty, 1'b1);
            chk("rst_fifo_full",  bus.fifo_full,  1'b0);
            chk("rst_frame_err",  bus.frame_err,  1'b0);
            chk("rst_cmd_count",  bus.cmd_count,  16'd0);
            chk("rst_rx_ready",   bus.rx_ready,   1'b1);
        end else begin
            chk("rx_ready",   bus.rx_ready,   exp_rdy());
            chk("fifo_empty", bus.fifo_empty, m_q.size() == 0);
            chk("fifo_full",  bus.fifo_full,  m_q.size() == DEPTH);
            chk("frame_err",  bus.frame_err,  m_err);
            chk("cmd_count",  bus.cmd_count,  m_cnt);
            if (m_q.size() > 0) chk("fifo_data", bus.fifo_data, m_q[0]);
            if (bus.frame_err) err_seen++;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the byte was accepted
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rx_ready && n < 200);
        chk("send_accept", bus.rx_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [79:0] p, input logic bad);
        logic [7:0] x;
        logic [7:0] bt;
        x = 8'h00;
        send_byte(8'hA5);
        for (int i = 0; i < 10; i++) begin
            bt = p[79-8*i -: 8];
            x  = x ^ bt;
            send_byte(bt);
        end
        send_byte(bad ? (x ^ 8'h01) : x);
    endtask

    task automatic drain();
        bus.fifo_rd_en = 1'b1;
        repeat (DEPTH + 1) @(posedge clk);
        #1;
        bus.fifo_rd_en = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [79:0] p4(input int i);
        return {32'h1000_0000 + 32'(i), 16'h0100, 32'h10 * 32'(i)};
    endfunction

    localparam logic [79:0] P1 = 80'h01000000_0400_00010000;
    localparam logic [79:0] P2 = 80'hA5A51234_0010_000000A5;
    localparam logic [79:0] PR = 80'h00BEEF00_0200_00000100;
    localparam logic [79:0] P6 = 80'h12345678_9ABC_DEF01122;

    initial begin : stim
        logic [7:0] t1 [11];
        logic [7:0] g  [3];
        int e0;
        int n;
        t1 = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
        g  = '{8'h00, 8'hFF, 8'h12};
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.fifo_rd_en = 1'b0;
        reset          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: single good frame, checksum 04
        for (int i = 0; i < 11; i++) send_byte(t1[i]);
        @(negedge clk);
        chk("t1_empty_before_csum", bus.fifo_empty, 1'b1);
        @(posedge clk);
        #1;
        send_byte(8'h04);
        @(negedge clk);
        chk("t1_empty_after", bus.fifo_empty, 1'b0);
        chk("t1_head", bus.fifo_data, P1);
        chk("t1_count", bus.cmd_count, 16'd1);
        @(posedge clk);
        #1;

        // 2: same frame with checksum 05
        e0 = err_seen;
        send_frame(P1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_err_pulses", 32'(err_seen - e0), 32'd1);
        chk("t2_count", bus.cmd_count, 16'd1);
        drain();
        chk("t2_drained", bus.fifo_empty, 1'b1);

        // 3: garbage then a frame whose payload contains sync bytes
        for (int i = 0; i < 3; i++) send_byte(g[i]);
        chk("t3_garbage_empty", bus.fifo_empty, 1'b1);
        send_frame(P2, 1'b0);
        @(negedge clk);
        chk("t3_count", bus.cmd_count, 16'd2);
        chk("t3_head", bus.fifo_data, P2);
        @(posedge clk);
        #1;
        drain();

        // 4: DEPTH+1 back-to-back frames, last checksum stalls until one pop
        pulse_reset();
        for (int i = 0; i < DEPTH; i++) send_frame(p4(i), 1'b0);
        fork
            send_frame(p4(DEPTH), 1'b0);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(bus.rx_valid && !bus.rx_ready) && n < 80);
                chk("t4_stall", bus.rx_ready, 1'b0);
                chk("t4_full", bus.fifo_full, 1'b1);
                @(posedge clk);
                #1;
                bus.fifo_rd_en = 1'b1;
                @(posedge clk);
                #1;
                bus.fifo_rd_en = 1'b0;
            end
        join
        @(negedge clk);
        chk("t4_count", bus.cmd_count, 16'd5);
        chk("t4_full_again", bus.fifo_full, 1'b1);
        chk("t4_head", bus.fifo_data, p4(1));
        @(posedge clk);
        #1;
        drain();

        // 5: reset after byte 6 of a frame, with an entry already stored
        send_frame(P1, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(t1[i]);
        pulse_reset();
        @(negedge clk);
        chk("t5_empty", bus.fifo_empty, 1'b1);
        chk("t5_count", bus.cmd_count, 16'd0);
        @(posedge clk);
        #1;
        send_frame(PR, 1'b0);
        @(negedge clk);
        chk("t5_count_after", bus.cmd_count, 16'd1);
        chk("t5_head", bus.fifo_data, PR);
        @(posedge clk);
        #1;
        drain();

        // 6: 120 idle cycles after byte 4, then the rest of the frame
        e0 = err_seen;
        for (int i = 0; i < 4; i++) send_byte(t1[i]);
        repeat (120) @(posedge clk);
        #1;
        for (int i = 4; i < 11; i++) send_byte(t1[i]);
        send_byte(8'h04);
        @(negedge clk);
`ifdef SWEEP_CMD_TIMEOUT_EN
        chk("t6_timeout_err", 32'(err_seen - e0), 32'd1);
        chk("t6_count", bus.cmd_count, 16'd1);
`else
        chk("t6_no_err", 32'(err_seen - e0), 32'd0);
        chk("t6_count", bus.cmd_count, 16'd2);
        chk("t6_head", bus.fifo_data, P1);
`endif
        @(posedge clk);
        #1;
        send_frame(P6, 1'b0);
        @(negedge clk);
`ifdef SWEEP_CMD_TIMEOUT_EN
        chk("t6_next_frame", bus.cmd_count, 16'd2);
`else
        chk("t6_next_frame", bus.cmd_count, 16'd3);
`endif
        @(posedge clk);
        #1;
        drain();
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish actual=running expected=done");
        $fatal(1, "watchdog");
    end

endmodule
